// File: rtl/peer_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peer_link_pkg
// Description : Shared widths, FSM encoding and word layout for the receive
//               end of the two-board versus link.
// Revision    : 1.0 - initial release
// ============================================================================
package peer_link_pkg;

    localparam int SCORE_W = 6;
    localparam int STATE_W = 3;
    localparam int WORD_W  = SCORE_W + STATE_W;
    localparam int PEND_W  = 4;

    // Link lock state: the first accepted word is only a baseline
    typedef enum logic [0:0] {
        WAIT_LOCK = 1'b0,
        LOCKED    = 1'b1
    } link_state_t;

    // Opponent bus word, score in the upper bits
    typedef struct packed {
        logic [SCORE_W-1:0] score;
        logic [STATE_W-1:0] state;
    } peer_word_t;

endpackage
`default_nettype wire

// File: rtl/peer_link_rx_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Parameterised-width two-flop synchroniser, cleared on reset.
//               Shared by the peer link, keypad and pushbutton inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/peer_link_rx.sv
`default_nettype none
// ============================================================================
// Module      : peer_link_rx
// Description : Receive end of the versus link. Synchronises the opponent's
//               static score/state bus, accepts a word only after it has been
//               identical for STABLE_CNT sample ticks, and turns score
//               increases into queued add-line requests.
//               Optional parity checking: define PEER_LINK_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module peer_link_rx
    import peer_link_pkg::*;
#(
    parameter int SAMPLE_DIV = 100,
    parameter int STABLE_CNT = 4,
    parameter int MAX_PEND   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score_in,
    input  logic [STATE_W-1:0] state_in,
    input  logic               add_line_ack,
`ifdef PEER_LINK_PARITY_EN
    input  logic               par_in,
    output logic [7:0]         par_err_cnt,
`endif
    output logic [SCORE_W-1:0] score_rx,
    output logic [STATE_W-1:0] state_rx,
    output logic               rx_valid,
    output logic               state_chg,
    output logic               add_line_req,
    output logic [PEND_W-1:0]  pend_cnt
);

    localparam int c_DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_STAB_W = $clog2(STABLE_CNT + 1);
    localparam int c_SUM_W  = SCORE_W + 2;

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(SAMPLE_DIV - 1);
    localparam logic [c_STAB_W-1:0] c_STAB_MAX = c_STAB_W'(STABLE_CNT);
    localparam logic [c_STAB_W-1:0] c_STAB_PRE = c_STAB_W'(STABLE_CNT - 1);
    localparam logic [c_SUM_W-1:0]  c_PEND_MAX = c_SUM_W'(MAX_PEND);

    peer_word_t           w_word;
    logic                 w_par_ok;
    logic                 w_tick;
    logic                 w_match;
    logic                 w_accept;
    logic [SCORE_W:0]     w_delta;
    logic [SCORE_W:0]     w_credit;
    logic                 w_ack_ok;
    logic [c_SUM_W-1:0]   w_sum;
    logic [PEND_W-1:0]    w_pend_next;

    logic [c_DIV_W-1:0]   r_div;
    peer_word_t           r_cand;
    logic [c_STAB_W-1:0]  r_stab;
    link_state_t          r_fsm;
    logic [SCORE_W-1:0]   r_score_rx;
    logic [STATE_W-1:0]   r_state_rx;
    logic                 r_rx_valid;
    logic                 r_state_chg;
    logic [PEND_W-1:0]    r_pend;

`ifdef PEER_LINK_PARITY_EN
    localparam int c_SYNC_W = WORD_W + 1;
    logic [c_SYNC_W-1:0]  w_sync;
    logic [7:0]           r_par_err;

    sync2 #(.WIDTH(c_SYNC_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({score_in, state_in, par_in}),
        .o_q   (w_sync)
    );

    assign w_word   = w_sync[c_SYNC_W-1:1];
    // Even parity: the XOR over word and parity bit must be zero
    assign w_par_ok = ~(^w_sync);

    // Saturating count of sample ticks that saw a parity error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= '0;
        end else if (w_tick && !w_par_ok && (r_par_err != 8'hFF)) begin
            r_par_err <= r_par_err + 8'd1;
        end
    end

    assign par_err_cnt = r_par_err;
`else
    sync2 #(.WIDTH(WORD_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({score_in, state_in}),
        .o_q   (w_word)
    );

    assign w_par_ok = 1'b1;
`endif

    // Free-running sample divider, tick on its last count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick   = (r_div == c_DIV_LAST);
    assign w_match  = (w_word == r_cand);
    // Fires once, on the tick that completes the run of identical samples
    assign w_accept = w_tick && w_par_ok && w_match && (r_stab == c_STAB_PRE);

    // Stability filter: track the candidate word and its run length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= '0;
            r_stab <= '0;
        end else if (w_tick) begin
            if (!w_par_ok) begin
                r_stab <= '0;
            end else if (w_match) begin
                if (r_stab != c_STAB_MAX) begin
                    r_stab <= r_stab + 1'b1;
                end
            end else begin
                r_cand <= w_word;
                r_stab <= c_STAB_W'(1);
            end
        end
    end

    // Credit is the score increase; a drop means the opponent restarted
    assign w_delta  = (r_cand.score > r_score_rx)
                    ? ({1'b0, r_cand.score} - {1'b0, r_score_rx})
                    : '0;
    assign w_credit = (w_accept && (r_fsm == LOCKED)) ? w_delta : '0;
    assign w_ack_ok = add_line_ack && (r_pend != '0);
    // Wide sum so saturation happens before truncating to the counter width
    assign w_sum    = c_SUM_W'(r_pend) + c_SUM_W'(w_credit) - c_SUM_W'(w_ack_ok);
    assign w_pend_next = (w_sum > c_PEND_MAX) ? PEND_W'(MAX_PEND) : w_sum[PEND_W-1:0];

    // Lock FSM with registered outputs and pending-line counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= WAIT_LOCK;
            r_score_rx  <= '0;
            r_state_rx  <= '0;
            r_rx_valid  <= 1'b0;
            r_state_chg <= 1'b0;
            r_pend      <= '0;
        end else begin
            r_state_chg <= 1'b0;
            r_pend      <= w_pend_next;
            case (r_fsm)
                WAIT_LOCK: begin
                    if (w_accept) begin
                        r_score_rx <= r_cand.score;
                        r_state_rx <= r_cand.state;
                        r_rx_valid <= 1'b1;
                        r_fsm      <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_accept) begin
                        r_score_rx  <= r_cand.score;
                        r_state_rx  <= r_cand.state;
                        r_state_chg <= (r_cand.state != r_state_rx);
                    end
                end
            endcase
        end
    end

    assign score_rx     = r_score_rx;
    assign state_rx     = r_state_rx;
    assign rx_valid     = r_rx_valid;
    assign state_chg    = r_state_chg;
    assign pend_cnt     = r_pend;
    assign add_line_req = (r_pend != '0);

endmodule
`default_nettype wire

// File: tb/tb_peer_link_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_peer_link_rx
// Description : Self-checking bench for peer_link_rx (SAMPLE_DIV=4,
//               STABLE_CNT=4): directed vector table, multi-cycle corner
//               sequences and a randomised run against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peer_link_rx;

    localparam int c_HOLD = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] score_in = '0;
    logic [2:0] state_in = '0;
    logic       add_line_ack = 1'b0;
    logic [5:0] score_rx;
    logic [2:0] state_rx;
    logic       rx_valid;
    logic       state_chg;
    logic       add_line_req;
    logic [3:0] pend_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int chg_cnt = 0;

    peer_link_rx #(
        .SAMPLE_DIV (4),
        .STABLE_CNT (4),
        .MAX_PEND   (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .score_in     (score_in),
        .state_in     (state_in),
        .add_line_ack (add_line_ack),
        .score_rx     (score_rx),
        .state_rx     (state_rx),
        .rx_valid     (rx_valid),
        .state_chg    (state_chg),
        .add_line_req (add_line_req),
        .pend_cnt     (pend_cnt)
    );

    always #5 clk = ~clk;

    // Cycle counter in phase with the sample divider (both cleared by reset)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Count every clock cycle in which state_chg is high
    always @(posedge clk) begin
        if (rst_n && state_chg) chg_cnt <= chg_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e_score, input int e_state,
                              input int e_pend, input int e_valid, input int e_chg,
                              input int chg0);
        check({tag, " score_rx"},     int'(score_rx),     e_score);
        check({tag, " state_rx"},     int'(state_rx),     e_state);
        check({tag, " pend_cnt"},     int'(pend_cnt),     e_pend);
        check({tag, " add_line_req"}, int'(add_line_req), (e_pend != 0) ? 1 : 0);
        check({tag, " rx_valid"},     int'(rx_valid),     e_valid);
        check({tag, " state_chg"},    chg_cnt - chg0,     e_chg);
    endtask

    task automatic do_reset(input int sc, input int st);
        rst_n        = 1'b0;
        add_line_ack = 1'b0;
        score_in     = 6'(sc);
        state_in     = 3'(st);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic ack_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            add_line_ack = 1'b1;
            @(negedge clk);
            add_line_ack = 1'b0;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int score;
        int state;
        int acks;
        int e_score;
        int e_state;
        int e_pend;
        int e_chg;
    } vec_t;

    vec_t vecs[11];

    // Word-level reference model state
    int m_score, m_state, m_pend;

    initial begin
        int chg0;
        int c0;

        vecs[0]  = '{5,  2, 0, 5,  2, 0,  0};
        vecs[1]  = '{8,  2, 0, 8,  2, 3,  0};
        vecs[2]  = '{8,  2, 1, 8,  2, 2,  0};
        vecs[3]  = '{8,  2, 1, 8,  2, 1,  0};
        vecs[4]  = '{8,  2, 1, 8,  2, 0,  0};
        vecs[5]  = '{8,  2, 1, 8,  2, 0,  0};
        vecs[6]  = '{3,  1, 0, 3,  1, 0,  1};
        vecs[7]  = '{3,  4, 0, 3,  4, 0,  1};
        vecs[8]  = '{0,  4, 0, 0,  4, 0,  0};
        vecs[9]  = '{40, 4, 0, 40, 4, 15, 0};
        vecs[10] = '{45, 4, 0, 45, 4, 15, 0};

        // ---- reset state and first lock latency ----
        @(negedge clk);
        do_reset(5, 2);
        chg0 = chg_cnt;
        check_outs("reset", 0, 0, 0, 0, 0, chg0);
        for (int i = 0; i < 21 && !rx_valid; i++) @(negedge clk);
        check("lock latency rx_valid", int'(rx_valid), 1);

        // ---- directed vector table ----
        for (int i = 0; i < 11; i++) begin
            chg0 = chg_cnt;
            score_in = 6'(vecs[i].score);
            state_in = 3'(vecs[i].state);
            repeat (c_HOLD) @(negedge clk);
            ack_pulses(vecs[i].acks);
            repeat (2) @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].e_score, vecs[i].e_state,
                       vecs[i].e_pend, 1, vecs[i].e_chg, chg0);
        end

        // ---- ack on the same cycle as an accept, saturated (pend 15, +2) ----
        while (cyc % 4 != 1) @(negedge clk);
        c0 = cyc;
        score_in = 6'd47;
        while (cyc != c0 + 14) @(negedge clk);
        add_line_ack = 1'b1;
        @(negedge clk);
        add_line_ack = 1'b0;
        repeat (20) @(negedge clk);
        check("coinc sat score_rx", int'(score_rx), 47);
        check("coinc sat pend_cnt", int'(pend_cnt), 15);

        // ---- same-cycle ack+accept below saturation: 3 + 2 - 1 = 4 ----
        ack_pulses(12);
        check("drain pend_cnt", int'(pend_cnt), 3);
        while (cyc % 4 != 1) @(negedge clk);
        c0 = cyc;
        score_in = 6'd49;
        while (cyc != c0 + 14) @(negedge clk);
        add_line_ack = 1'b1;
        @(negedge clk);
        add_line_ack = 1'b0;
        repeat (20) @(negedge clk);
        check("coinc score_rx", int'(score_rx), 49);
        check("coinc pend_cnt", int'(pend_cnt), 4);

        // ---- glitchy bus: 5 <-> 9 every 6 cycles never accepted ----
        do_reset(5, 2);
        repeat (c_HOLD) @(negedge clk);
        chg0 = chg_cnt;
        for (int i = 0; i < 34; i++) begin
            score_in = (i % 2 == 0) ? 6'd9 : 6'd5;
            repeat (6) @(negedge clk);
        end
        check_outs("toggle", 5, 2, 0, 1, 0, chg0);

        // ---- asynchronous reset mid-filter with pend = 7 ----
        do_reset(0, 0);
        repeat (c_HOLD) @(negedge clk);
        score_in = 6'd7;
        repeat (c_HOLD) @(negedge clk);
        check("pre-reset pend_cnt", int'(pend_cnt), 7);
        score_in = 6'd20;
        state_in = 3'd5;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst score_rx",     int'(score_rx),     0);
        check("async rst state_rx",     int'(state_rx),     0);
        check("async rst rx_valid",     int'(rx_valid),     0);
        check("async rst state_chg",    int'(state_chg),    0);
        check("async rst add_line_req", int'(add_line_req), 0);
        check("async rst pend_cnt",     int'(pend_cnt),     0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chg0 = chg_cnt;
        repeat (c_HOLD) @(negedge clk);
        check_outs("post-reset baseline", 20, 5, 0, 1, 0, chg0);

        // ---- randomised words, glitches and acks against the model ----
        m_score = 20;
        m_state = 5;
        m_pend  = 0;
        for (int s = 0; s < 40; s++) begin
            int ns, nst, e_chg, acks, r;
            r = int'($urandom_range(0, 3));
            if (r == 0)      ns = m_score;
            else if (r == 1) ns = int'($urandom_range(0, m_score));
            else             ns = int'($urandom_range(0, 63));
            nst  = ($urandom_range(0, 2) == 0) ? m_state : int'($urandom_range(0, 7));
            chg0 = chg_cnt;
            if ($urandom_range(0, 1) == 1) begin
                score_in = 6'($urandom_range(0, 63));
                state_in = 3'($urandom_range(0, 7));
                @(negedge clk);
            end
            score_in = 6'(ns);
            state_in = 3'(nst);
            repeat (c_HOLD) @(negedge clk);

            e_chg = (nst != m_state) ? 1 : 0;
            if (ns > m_score) begin
                m_pend = m_pend + (ns - m_score);
                if (m_pend > 15) m_pend = 15;
            end
            m_score = ns;
            m_state = nst;

            acks = int'($urandom_range(0, 4));
            ack_pulses(acks);
            for (int k = 0; k < acks; k++) begin
                if (m_pend > 0) m_pend--;
            end
            repeat (2) @(negedge clk);
            check_outs($sformatf("rand%0d", s), m_score, m_state, m_pend, 1, e_chg, chg0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
